// File: rtl/sipo.sv
// sipo: MSB-first serial-to-parallel deserializer with valid/ack output and sticky overrun
module sipo #(
  parameter int SIZE = 8
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic            serial_in,
  input  logic            shift_en_in,
  input  logic            sync_in,
  input  logic            ack_in,
  output logic [SIZE-1:0] data_out,
  output logic            valid_out,
  output logic            overrun_out
);
  localparam int CW = $clog2(SIZE);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          state, state_nxt;
  logic [CW-1:0]   r_count, count_nxt;
  logic [SIZE-1:0] r_shift, shift_nxt, word;
  logic            complete, load;
  // sync suppresses completion; a FULL output accepts a new word only when acked on the same edge
  always_comb begin
    complete  = shift_en_in && !sync_in && r_count == '0;
    word      = {r_shift[SIZE-1:1], serial_in};
    load      = complete && (state == EMPTY || ack_in);
    state_nxt = complete ? FULL : (state == FULL && ack_in) ? EMPTY : state;
    count_nxt = sync_in ? (shift_en_in ? CW'(SIZE-2) : CW'(SIZE-1)) :
                !shift_en_in ? r_count :
                r_count == '0 ? CW'(SIZE-1) : r_count - 1'b1;
    shift_nxt = r_shift;
    if (shift_en_in) shift_nxt[r_count] = serial_in;
    if (sync_in) shift_nxt = {serial_in & shift_en_in, {(SIZE-1){1'b0}}};
  end
  // framing state, output register and sticky overrun flag
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_count     <= CW'(SIZE-1);
      r_shift     <= '0;
      state       <= EMPTY;
      data_out    <= '0;
      overrun_out <= 1'b0;
    end else begin
      r_count     <= count_nxt;
      r_shift     <= shift_nxt;
      state       <= state_nxt;
      data_out    <= load ? word : data_out;
      overrun_out <= overrun_out | (complete & !load);
    end
  end
  assign valid_out = state == FULL;
endmodule

// File: tb/tb_sipo.sv
// tb_sipo: scoreboard-driven bench for the sipo deserializer
module tb_sipo;
  logic       clk_in = 1'b0;
  logic       reset_n_in = 1'b1;
  logic       serial_in = 1'b0;
  logic       shift_en_in = 1'b0;
  logic       sync_in = 1'b0;
  logic       ack_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       overrun_out;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];

  sipo #(.SIZE(8)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .serial_in(serial_in),
    .shift_en_in(shift_en_in), .sync_in(sync_in), .ack_in(ack_in),
    .data_out(data_out), .valid_out(valid_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input logic s, input logic en, input logic sy, input logic ak);
    serial_in = s; shift_en_in = en; sync_in = sy; ack_in = ak;
    @(posedge clk_in);
    #1;
    serial_in = 0; shift_en_in = 0; sync_in = 0; ack_in = 0;
  endtask

  task automatic do_reset();
    reset_n_in = 0;
    @(posedge clk_in);
    #1;
    reset_n_in = 1;
  endtask

  task automatic send(input logic [7:0] w, input bit alt, input bit ack_last);
    for (int i = 7; i >= 0; i--) begin
      tick(w[i], 1, 0, ack_last && i == 0);
      if (alt && i != 0) tick(1, 0, 0, 0);
    end
  endtask

  task automatic check_word(input string name, input logic ev, input logic eo);
    logic [7:0] exp;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, data_out=%h", name, data_out);
      return;
    end
    exp = sb.pop_front();
    if (data_out !== exp) begin
      n_fail++;
      $display("FAIL %s data: got %h expected %h", name, data_out, exp);
    end
    n_tests++;
    if (valid_out !== ev) begin
      n_fail++;
      $display("FAIL %s valid: got %b expected %b", name, valid_out, ev);
    end
    n_tests++;
    if (overrun_out !== eo) begin
      n_fail++;
      $display("FAIL %s overrun: got %b expected %b", name, overrun_out, eo);
    end
  endtask

  task automatic test_reset();
    #1 reset_n_in = 0;
    #1;
    sb.push_back(8'h00);
    check_word("reset_async", 0, 0);
    @(posedge clk_in);
    #1 reset_n_in = 1;
  endtask

  task automatic test_basic();
    do_reset();
    send(8'hA5, 0, 0);
    sb.push_back(8'hA5);
    check_word("basic_a5", 1, 0);
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 7; i >= 1; i--) begin
      tick(8'hA5 >> i, 1, 0, 0);
      tick(1, 0, 0, 0);
    end
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL alt_early_valid: got %b expected 0", valid_out);
    end
    tick(1, 1, 0, 0);
    sb.push_back(8'hA5);
    check_word("alt_a5", 1, 0);
  endtask

  task automatic test_overrun();
    do_reset();
    send(8'h3C, 0, 0);
    sb.push_back(8'h3C);
    check_word("ovr_first", 1, 0);
    send(8'hFF, 0, 0);
    sb.push_back(8'h3C);
    check_word("ovr_drop", 1, 1);
    tick(0, 0, 0, 1);
    sb.push_back(8'h3C);
    check_word("ovr_sticky", 0, 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'h12, 0, 0);
    sb.push_back(8'h12);
    check_word("b2b_first", 1, 0);
    send(8'h34, 0, 1);
    sb.push_back(8'h34);
    check_word("b2b_ack_collide", 1, 0);
    tick(0, 0, 0, 1);
    sb.push_back(8'h34);
    check_word("b2b_ack_clear", 0, 0);
  endtask

  task automatic test_sync();
    logic [6:0] tail;
    do_reset();
    tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    tail = 7'b0000001;
    for (int i = 6; i >= 0; i--) tick(tail[i], 1, 0, 0);
    sb.push_back(8'h81);
    check_word("sync_81", 1, 0);
  endtask

  task automatic test_sync_index0();
    logic [6:0] tail;
    do_reset();
    for (int i = 0; i < 7; i++) tick(1, 1, 0, 0);
    tick(0, 1, 1, 0);
    sb.push_back(8'h00);
    check_word("sync_idx0_nocomplete", 0, 0);
    tail = 7'b1010101;
    for (int i = 6; i >= 0; i--) tick(tail[i], 1, 0, 0);
    sb.push_back(8'h55);
    check_word("sync_idx0_55", 1, 0);
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(8'hA5, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
    #2 reset_n_in = 0;
    #1;
    sb.push_back(8'h00);
    check_word("midreset_async", 0, 0);
    @(posedge clk_in);
    #1 reset_n_in = 1;
    send(8'h5A, 0, 0);
    sb.push_back(8'h5A);
    check_word("midreset_5a", 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_overrun();
    test_back_to_back();
    test_sync();
    test_sync_index0();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
